// File: rtl/clk_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_pkg
// Shared definitions for the run-time clock divider controller.
//   DEF_DATA_WIDTH : default width of the divide ratio and internal counter
//   div_state_t    : controller states (IDLE / RUN / PEND)
// ---------------------------------------------------------------------------
package clk_div_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,   // stopped, ratio 0 or never configured
      DIV_RUN  = 2'b01,   // dividing with ratio_cur
      DIV_PEND = 2'b10    // dividing with ratio_cur, new ratio waiting for a period boundary
   } div_state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_if
// Configuration handshake between a requester and the divider controller.
//   cfg_req   : requester -> controller, held high until cfg_ack is seen
//   cfg_ratio : requester -> controller, requested divide ratio N
//   cfg_ack   : controller -> requester, one-cycle pulse when N is applied
//   cfg_busy  : controller -> requester, high while an update is pending
// Modports: master (requester side), slave (controller side).
// ---------------------------------------------------------------------------
interface clk_div_ctrl_if
   import clk_div_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  cfg_req;
   logic [DATA_WIDTH-1:0] cfg_ratio;
   logic                  cfg_ack;
   logic                  cfg_busy;

   modport master (
      output cfg_req,
      output cfg_ratio,
      input  cfg_ack,
      input  cfg_busy
   );

   modport slave (
      input  cfg_req,
      input  cfg_ratio,
      output cfg_ack,
      output cfg_busy
   );
endinterface

// File: rtl/clk_div_ctrl_counter.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_counter
// Wrapping half-period counter: counts 0..ratio-1 while enabled and flags the
// last count.
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   enable   : advance the counter this cycle
//   clear    : synchronous restart at 0 (wins over enable)
//   ratio    : current divide ratio N (N >= 1 whenever enable is high)
//   terminal : combinational, cnt == N-1
// ---------------------------------------------------------------------------
module clk_div_ctrl_counter
   import clk_div_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] ratio,
   output logic                  terminal
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] cnt_reg;
   logic [DATA_WIDTH-1:0] last_cnt;

   // ratio 0 wraps last_cnt to all-ones; the controller never enables the
   // counter in that case, so the value is harmless.
   assign last_cnt = ratio - ONE;
   assign terminal = (cnt_reg == last_cnt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (enable) begin
         cnt_reg <= terminal ? '0 : cnt_reg + ONE;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for the programmable clock divider. Ratio updates are
// accepted over a req/ack handshake and applied only when clk_out falls at
// the end of a full period, so the divided clock never glitches.
//   clk       : system clock, all logic on the rising edge
//   reset     : asynchronous, active-low reset
//   enable    : run gate; low freezes the counter, clk_out and a pending apply
//   cfg       : configuration handshake (slave side)
//   ratio_cur : ratio currently in force
//   tick      : combinational, one cycle at the end of every N-cycle half-period
//   clk_out   : registered divided clock, fclk/(2N), 50% duty
// ---------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   clk_div_ctrl_if.slave         cfg,
   output logic [DATA_WIDTH-1:0] ratio_cur,
   output logic                  tick,
   output logic                  clk_out
);

   div_state_t            state_reg, state_next;
   logic [DATA_WIDTH-1:0] ratio_reg, ratio_next;
   logic [DATA_WIDTH-1:0] pending_reg, pending_next;
   logic                  clk_out_reg, clk_out_next;
   logic                  ack_reg, ack_next;
   logic                  busy_reg, busy_next;

   logic                  running;
   logic                  terminal;
   logic                  cnt_clear;
   logic                  req_valid;
   logic                  apply_pend;

   // A request seen in the same cycle as our ack is the one just served.
   assign req_valid  = cfg.cfg_req & ~ack_reg;
   assign running    = (state_reg != DIV_IDLE);
   assign tick       = running & enable & terminal;
   // Switching only while clk_out is high and about to fall keeps the
   // current period whole.
   assign apply_pend = (state_reg == DIV_PEND) & tick & clk_out_reg;

   clk_div_ctrl_counter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .enable   (running & enable),
      .clear    (cnt_clear),
      .ratio    (ratio_reg),
      .terminal (terminal)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= DIV_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         DIV_IDLE: begin
            if (req_valid) begin
               state_next = (cfg.cfg_ratio != '0) ? DIV_RUN : DIV_IDLE;
            end
         end
         DIV_RUN: begin
            if (req_valid) begin
               state_next = DIV_PEND;
            end
         end
         DIV_PEND: begin
            if (apply_pend) begin
               state_next = (pending_reg != '0) ? DIV_RUN : DIV_IDLE;
            end
         end
         default: state_next = DIV_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      ratio_next   = ratio_reg;
      pending_next = pending_reg;
      clk_out_next = clk_out_reg ^ tick;
      ack_next     = 1'b0;
      cnt_clear    = 1'b0;
      unique case (state_reg)
         DIV_IDLE: begin
            // Applies immediately; does not wait on enable.
            if (req_valid) begin
               ratio_next   = cfg.cfg_ratio;
               cnt_clear    = 1'b1;
               clk_out_next = 1'b0;
               ack_next     = 1'b1;
            end
         end
         DIV_RUN: begin
            if (req_valid) begin
               pending_next = cfg.cfg_ratio;
            end
         end
         DIV_PEND: begin
            if (apply_pend) begin
               ratio_next   = pending_reg;
               cnt_clear    = 1'b1;
               clk_out_next = 1'b0;
               ack_next     = 1'b1;
            end
         end
         default: begin
            ratio_next = ratio_reg;
         end
      endcase
      busy_next = (state_next == DIV_PEND);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ratio_reg   <= '0;
         pending_reg <= '0;
         clk_out_reg <= 1'b0;
         ack_reg     <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         ratio_reg   <= ratio_next;
         pending_reg <= pending_next;
         clk_out_reg <= clk_out_next;
         ack_reg     <= ack_next;
         busy_reg    <= busy_next;
      end
   end

   assign ratio_cur    = ratio_reg;
   assign clk_out      = clk_out_reg;
   assign cfg.cfg_ack  = ack_reg;
   assign cfg.cfg_busy = busy_reg;

endmodule
